// File: rtl/result_display_queue_pkg.sv
// Shared types and constants for the result display queue.
package result_display_queue_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int DWELL_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Active-high segment codes, bit 0 = a .. bit 6 = g, indexed by digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to 7-segment pattern decoder.
module hex7seg_decode
    import result_display_queue_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/result_display_queue.sv
// Small FIFO of adder results, each shown on a 7-segment display for DWELL
// cycles. Overflowing results are dropped and flagged on the decimal point.
module result_display_queue
    import result_display_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_sum,
    output logic       in_ready,
    input  logic       clear,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic [3:0] count
);

    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);
    localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          drop_q, drop_d;
    state_t        state_q, state_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [3:0]    disp_q, disp_d;
    logic          push, pop;
    logic [6:0]    seg_dec;

    // Readiness comes only from registered occupancy, so a same-cycle pop
    // never frees a slot for a same-cycle push.
    assign in_ready = (cnt_q != FULL_CNT);
    assign push     = in_valid && in_ready && !clear;

    // FSM next state: pop the head whenever idle or a dwell has expired.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        disp_d  = disp_q;
        pop     = 1'b0;
        if (clear) begin
            state_d = IDLE;
            dwell_d = '0;
            disp_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q != 4'd0) begin
                        pop     = 1'b1;
                        disp_d  = mem_q[rd_q];
                        dwell_d = DWELL_LD;
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (dwell_q != 8'd0) begin
                        dwell_d = dwell_q - 8'd1;
                    end else if (cnt_q != 4'd0) begin
                        pop     = 1'b1;
                        disp_d  = mem_q[rd_q];
                        dwell_d = DWELL_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Queue pointer, occupancy and sticky drop-flag next state.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (clear) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            drop_d = 1'b0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 4'd1;
                2'b01:   cnt_d = cnt_q - 4'd1;
                default: cnt_d = cnt_q;
            endcase
            if (in_valid && !in_ready) drop_d = 1'b1;
        end
    end

    // Control and display state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            disp_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            disp_q  <= disp_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_sum;
    end

    hex7seg_decode u_dec (
        .hex_i (disp_q),
        .seg_o (seg_dec)
    );

    assign seg   = (state_q == SHOW) ? seg_dec : 7'h00;
    assign busy  = (state_q == SHOW);
    assign dp    = drop_q;
    assign count = cnt_q;

endmodule
